// File: rtl/bp_common_pkg.sv
// Shared constants for the performance-counter drain: event indices, dump FSM
// states and the bit layout of the dump header word.
package bp_common_pkg;

  localparam int e_perf_cycles       = 0;
  localparam int e_perf_bp_correct   = 1;
  localparam int e_perf_bp_incorrect = 2;
  localparam int e_perf_lce_req      = 3;
  localparam int e_perf_cce_req      = 4;
  localparam int e_perf_sb_miss      = 5;

  // Header word: counter count in [7:0], any-overflow flag in bit 8.
  localparam int hdr_cnt_lsb = 0;
  localparam int hdr_cnt_msb = 7;
  localparam int hdr_ovf_bit = 8;

  typedef enum logic [1:0] {
    e_dump_idle   = 2'd0,
    e_dump_header = 2'd1,
    e_dump_stream = 2'd2
  } dump_state_e;

endpackage

// File: rtl/bp_perf_counter_dump_if.sv
// Dump request and readout stream between the counter block (master) and a
// host or trace sink (slave).
//
// Handshake: a request is taken when dump_v_i && dump_ready_o; a word moves
// when data_v_o && data_ready_i. Once data_v_o rises, data_o, data_idx_o and
// data_last_o hold steady and data_v_o stays high until that word moves.
interface bp_perf_counter_dump_if #(
  parameter int num_events_p    = 5,
  parameter int counter_width_p = 32
);
  localparam int idx_width_lp = $clog2(num_events_p + 2);

  logic                       dump_v_i;
  logic                       dump_ready_o;
  logic                       data_v_o;
  logic [counter_width_p-1:0] data_o;
  logic [idx_width_lp-1:0]    data_idx_o;
  logic                       data_last_o;
  logic                       data_ready_i;

  modport master (
    input  dump_v_i, data_ready_i,
    output dump_ready_o, data_v_o, data_o, data_idx_o, data_last_o
  );

  modport slave (
    output dump_v_i, data_ready_i,
    input  dump_ready_o, data_v_o, data_o, data_idx_o, data_last_o
  );

endinterface

// File: rtl/bp_perf_sat_counter.sv
// One saturating event counter with sticky overflow. next_o is the value the
// counter takes this cycle before any clear, so a snapshot can include it.
module bp_perf_sat_counter #(
  parameter int width_p = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  input  logic               inc_i,
  input  logic               clear_i,
  output logic [width_p-1:0] next_o,
  output logic               ovf_o,
  output logic               ovf_next_o
);

  logic [width_p-1:0] cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               step;
  logic               at_max;

  always_comb begin
    step       = en_i & inc_i;
    at_max     = &cnt_q;
    next_o     = (step && !at_max) ? cnt_q + width_p'(1) : cnt_q;
    ovf_next_o = ovf_q | (step & at_max);
    cnt_d      = clear_i ? '0 : next_o;
    ovf_d      = clear_i ? 1'b0 : ovf_next_o;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;

endmodule

// File: rtl/bp_perf_counter_dump.sv
// Performance-event accumulator: cycle counter plus per-event counters, with a
// snapshot-and-stream readout (header word, then one word per counter).
module bp_perf_counter_dump
  import bp_common_pkg::*;
#(
  parameter int num_events_p    = 5,
  parameter int counter_width_p = 32,
  parameter int clear_on_dump_p = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_i,
  input  logic [num_events_p-1:0] event_v_i,
  bp_perf_counter_dump_if.master  link,
  output logic [num_events_p:0]   overflow_o,
  output dump_state_e             dbg_state_o
);

  localparam int num_ctr_lp   = num_events_p + 1;
  localparam int idx_width_lp = $clog2(num_events_p + 2);
  localparam int hdr_w_lp     = (counter_width_p > hdr_ovf_bit) ? counter_width_p : hdr_ovf_bit + 1;

  logic [num_ctr_lp-1:0]                      inc;
  logic [num_ctr_lp-1:0][counter_width_p-1:0] cnt_next;
  logic [num_ctr_lp-1:0]                      ovf_next;
  logic                                       dump_accept;
  logic                                       clear_en;

  logic [num_ctr_lp-1:0][counter_width_p-1:0] snap_q;
  logic                                       snap_ovf_q;
  dump_state_e                                state_q, state_d;
  logic [idx_width_lp-1:0]                    ptr_q, ptr_d;
  logic                                       last_w;
  logic [hdr_w_lp-1:0]                        hdr_full;

  always_comb begin
    inc                = '0;
    inc[e_perf_cycles] = 1'b1;
    inc[num_ctr_lp-1:1] = event_v_i;
  end

  assign dump_accept = (state_q == e_dump_idle) && link.dump_v_i;
  assign clear_en    = dump_accept && (clear_on_dump_p != 0);

  for (genvar i = 0; i < num_ctr_lp; i++) begin : g_ctr
    bp_perf_sat_counter #(.width_p(counter_width_p)) u_ctr (
      .clk        (clk),
      .reset      (reset),
      .en_i       (en_i),
      .inc_i      (inc[i]),
      .clear_i    (clear_en),
      .next_o     (cnt_next[i]),
      .ovf_o      (overflow_o[i]),
      .ovf_next_o (ovf_next[i])
    );
  end

  // Snapshot takes the post-increment values so a dump-cycle event is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q     <= '0;
      snap_ovf_q <= 1'b0;
    end else if (dump_accept) begin
      snap_q     <= cnt_next;
      snap_ovf_q <= |ovf_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= e_dump_idle;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign last_w = (state_q == e_dump_stream) && (ptr_q == idx_width_lp'(num_events_p));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      e_dump_idle: begin
        if (link.dump_v_i) state_d = e_dump_header;
      end
      e_dump_header: begin
        if (link.data_ready_i) begin
          state_d = e_dump_stream;
          ptr_d   = '0;
        end
      end
      e_dump_stream: begin
        if (link.data_ready_i) begin
          if (last_w) begin
            state_d = e_dump_idle;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + idx_width_lp'(1);
          end
        end
      end
      default: begin
        state_d = e_dump_idle;
        ptr_d   = '0;
      end
    endcase
  end

  always_comb begin
    hdr_full                          = '0;
    hdr_full[hdr_cnt_msb:hdr_cnt_lsb] = 8'(num_ctr_lp);
    hdr_full[hdr_ovf_bit]             = snap_ovf_q;
  end

  // Outputs decode straight from registered state, so reset clears them at once.
  always_comb begin
    link.dump_ready_o = 1'b0;
    link.data_v_o     = 1'b0;
    link.data_o       = '0;
    link.data_idx_o   = '0;
    link.data_last_o  = 1'b0;
    case (state_q)
      e_dump_idle: link.dump_ready_o = 1'b1;
      e_dump_header: begin
        link.data_v_o = 1'b1;
        link.data_o   = hdr_full[counter_width_p-1:0];
      end
      e_dump_stream: begin
        link.data_v_o    = 1'b1;
        link.data_o      = snap_q[ptr_q];
        link.data_idx_o  = ptr_q + idx_width_lp'(1);
        link.data_last_o = last_w;
      end
      default: link.dump_ready_o = 1'b0;
    endcase
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bp_perf_counter_dump.sv
// Directed bench for bp_perf_counter_dump: a 32-bit instance for the dump
// flow and an 8-bit instance for saturation.
module tb_bp_perf_counter_dump;
  import bp_common_pkg::*;

  logic        clk;
  logic        reset;
  logic        en;
  logic [4:0]  ev;
  logic [5:0]  ovf;
  dump_state_e dbg;

  logic        s_en;
  logic [4:0]  s_ev;
  logic [5:0]  s_ovf;
  dump_state_e s_dbg;

  int errors;
  int checks;

  bp_perf_counter_dump_if #(.num_events_p(5), .counter_width_p(32)) m_if ();
  bp_perf_counter_dump_if #(.num_events_p(5), .counter_width_p(8))  s_if ();

  bp_perf_counter_dump #(.num_events_p(5), .counter_width_p(32), .clear_on_dump_p(1)) u_dut (
    .clk(clk), .reset(reset), .en_i(en), .event_v_i(ev), .link(m_if),
    .overflow_o(ovf), .dbg_state_o(dbg)
  );

  bp_perf_counter_dump #(.num_events_p(5), .counter_width_p(8), .clear_on_dump_p(1)) u_sat (
    .clk(clk), .reset(reset), .en_i(s_en), .event_v_i(s_ev), .link(s_if),
    .overflow_o(s_ovf), .dbg_state_o(s_dbg)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // captured readout of one dump on the 32-bit instance
  logic [31:0] w_data [7];
  logic [2:0]  w_idx  [7];
  logic        w_last [7];
  int          w_cyc  [7];
  int          got_n;
  int          hold_viol;
  int          total_ticks;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dump();
    m_if.dump_v_i = 1'b1;
    tick();
    m_if.dump_v_i = 1'b0;
  endtask

  // Drains one dump; bp=1 applies ready pattern 0,0,1 and raises dump_v_i
  // while word 2 is pending.
  task automatic collect(input bit bp);
    int phase;
    bit got;
    bit have;
    logic [31:0] hd;
    logic [2:0]  hi;
    logic        hl;
    phase = 0; got_n = 0; hold_viol = 0; total_ticks = 0;
    for (int w = 0; w < 7; w++) begin
      w_data[w] = 'x; w_idx[w] = 'x; w_last[w] = 1'bx; w_cyc[w] = 0;
    end
    for (int w = 0; w < 7; w++) begin
      got = 1'b0; have = 1'b0; hd = '0; hi = '0; hl = 1'b0;
      for (int c = 0; c < 12 && !got; c++) begin
        m_if.data_ready_i = bp ? (phase == 2) : 1'b1;
        if (bp) m_if.dump_v_i = (w == 2);
        @(negedge clk);
        if (m_if.data_v_o) begin
          if (have && (m_if.data_o !== hd || m_if.data_idx_o !== hi || m_if.data_last_o !== hl))
            hold_viol++;
          hd = m_if.data_o; hi = m_if.data_idx_o; hl = m_if.data_last_o; have = 1'b1;
          if (m_if.data_ready_i) begin
            w_data[w] = m_if.data_o; w_idx[w] = m_if.data_idx_o; w_last[w] = m_if.data_last_o;
            got = 1'b1; got_n++;
          end
        end
        phase = (phase == 2) ? 0 : phase + 1;
        tick();
        w_cyc[w]++; total_ticks++;
      end
    end
    m_if.dump_v_i = 1'b0;
    m_if.data_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    checks++; if (m_if.data_v_o !== 1'b0) begin errors++; $display("FAIL reset_data_v got=%0b exp=0", m_if.data_v_o); end
    checks++; if (m_if.dump_ready_o !== 1'b1) begin errors++; $display("FAIL reset_dump_ready got=%0b exp=1", m_if.dump_ready_o); end
    checks++; if (m_if.data_o !== 32'd0) begin errors++; $display("FAIL reset_data got=%0h exp=0", m_if.data_o); end
    checks++; if (m_if.data_idx_o !== 3'd0 || m_if.data_last_o !== 1'b0) begin errors++; $display("FAIL reset_idx_last got=%0d/%0b exp=0/0", m_if.data_idx_o, m_if.data_last_o); end
    checks++; if (ovf !== 6'd0) begin errors++; $display("FAIL reset_overflow got=%0h exp=0", ovf); end
    checks++; if (dbg !== e_dump_idle) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg, e_dump_idle); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] exp [7];
    exp = '{32'h006, 32'd11, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    en = 1'b1;
    repeat (10) tick();
    start_dump();
    checks++; if (m_if.dump_ready_o !== 1'b0 || dbg !== e_dump_header) begin errors++; $display("FAIL basic_in_header ready=%0b state=%0d exp ready=0 state=%0d", m_if.dump_ready_o, dbg, e_dump_header); end
    collect(1'b0);
    checks++; if (got_n !== 7 || total_ticks !== 7) begin errors++; $display("FAIL basic_throughput words=%0d ticks=%0d exp 7/7", got_n, total_ticks); end
    for (int w = 0; w < 7; w++) begin
      checks++; if (w_data[w] !== exp[w]) begin errors++; $display("FAIL basic_data[%0d] got=%0h exp=%0h", w, w_data[w], exp[w]); end
      checks++; if (w_idx[w] !== 3'(w) || w_last[w] !== (w == 6)) begin errors++; $display("FAIL basic_idx_last[%0d] got=%0d/%0b exp=%0d/%0b", w, w_idx[w], w_last[w], w, (w == 6)); end
    end
    checks++; if (m_if.dump_ready_o !== 1'b1 || m_if.data_v_o !== 1'b0) begin errors++; $display("FAIL basic_done ready=%0b valid=%0b exp 1/0", m_if.dump_ready_o, m_if.data_v_o); end
  endtask

  task automatic test_events();
    ev = 5'b00001; tick();
    ev = 5'b00001; tick();
    ev = 5'b00010; tick();
    ev = 5'b00001; tick();
    ev = 5'b00001; start_dump(); ev = 5'b00000;
    collect(1'b0);
    checks++; if (w_data[0] !== 32'h006) begin errors++; $display("FAIL events_header got=%0h exp=6", w_data[0]); end
    checks++; if (w_data[1] !== 32'd12) begin errors++; $display("FAIL events_cycles got=%0d exp=12", w_data[1]); end
    checks++; if (w_data[2] !== 32'd4) begin errors++; $display("FAIL events_ctr1 got=%0d exp=4", w_data[2]); end
    checks++; if (w_data[3] !== 32'd1) begin errors++; $display("FAIL events_ctr2 got=%0d exp=1", w_data[3]); end
    checks++; if (w_data[4] !== 32'd0 || w_data[5] !== 32'd0 || w_data[6] !== 32'd0) begin errors++; $display("FAIL events_quiet got=%0d,%0d,%0d exp 0,0,0", w_data[4], w_data[5], w_data[6]); end
    start_dump();
    collect(1'b0);
    checks++; if (w_data[1] !== 32'd8) begin errors++; $display("FAIL events_redump_cycles got=%0d exp=8", w_data[1]); end
    checks++; if (w_data[2] !== 32'd0 || w_data[3] !== 32'd0) begin errors++; $display("FAIL events_redump_cleared got=%0d,%0d exp 0,0", w_data[2], w_data[3]); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [7];
    exp = '{32'h006, 32'd8, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    start_dump();
    ev = 5'b10000;
    collect(1'b1);
    ev = 5'b00000;
    checks++; if (got_n !== 7 || hold_viol !== 0) begin errors++; $display("FAIL bp_words_hold words=%0d changes=%0d exp 7/0", got_n, hold_viol); end
    for (int w = 0; w < 7; w++) begin
      checks++; if (w_cyc[w] !== 3) begin errors++; $display("FAIL bp_word_cycles[%0d] got=%0d exp=3", w, w_cyc[w]); end
      checks++; if (w_data[w] !== exp[w] || w_idx[w] !== 3'(w) || w_last[w] !== (w == 6)) begin errors++; $display("FAIL bp_word[%0d] got=%0h/%0d/%0b exp=%0h/%0d/%0b", w, w_data[w], w_idx[w], w_last[w], exp[w], w, (w == 6)); end
    end
    checks++; if (m_if.dump_ready_o !== 1'b1 || m_if.data_v_o !== 1'b0) begin errors++; $display("FAIL bp_ignored_dump ready=%0b valid=%0b exp 1/0", m_if.dump_ready_o, m_if.data_v_o); end
    start_dump();
    collect(1'b0);
    checks++; if (w_data[1] !== 32'd22) begin errors++; $display("FAIL bp_kept_counting_cycles got=%0d exp=22", w_data[1]); end
    checks++; if (w_data[6] !== 32'd21) begin errors++; $display("FAIL bp_kept_counting_ctr5 got=%0d exp=21", w_data[6]); end
  endtask

  task automatic test_enable();
    en = 1'b0; ev = 5'b00001;
    repeat (5) tick();
    en = 1'b1; ev = 5'b00010; tick();
    ev = 5'b00000;
    repeat (4) tick();
    en = 1'b0;
    start_dump();
    en = 1'b1;
    collect(1'b0);
    checks++; if (w_data[1] !== 32'd12) begin errors++; $display("FAIL enable_cycles got=%0d exp=12", w_data[1]); end
    checks++; if (w_data[2] !== 32'd0) begin errors++; $display("FAIL enable_masked_event got=%0d exp=0", w_data[2]); end
    checks++; if (w_data[3] !== 32'd1) begin errors++; $display("FAIL enable_counted_event got=%0d exp=1", w_data[3]); end
  endtask

  task automatic test_reset_mid_stream();
    start_dump();
    repeat (3) tick();
    checks++; if (m_if.data_v_o !== 1'b1 || m_if.data_idx_o !== 3'd3) begin errors++; $display("FAIL midrst_pre valid=%0b idx=%0d exp 1/3", m_if.data_v_o, m_if.data_idx_o); end
    reset = 1'b1;
    #1;
    checks++; if (m_if.data_v_o !== 1'b0 || m_if.dump_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_async valid=%0b ready=%0b exp 0/1", m_if.data_v_o, m_if.dump_ready_o); end
    checks++; if (m_if.data_idx_o !== 3'd0 || m_if.data_o !== 32'd0 || dbg !== e_dump_idle) begin errors++; $display("FAIL midrst_outputs idx=%0d data=%0h state=%0d exp 0/0/0", m_if.data_idx_o, m_if.data_o, dbg); end
    tick();
    en = 1'b0; reset = 1'b0;
    tick();
    start_dump();
    en = 1'b1;
    collect(1'b0);
    checks++; if (w_data[0] !== 32'h006 || got_n !== 7) begin errors++; $display("FAIL midrst_header got=%0h words=%0d exp 6/7", w_data[0], got_n); end
    for (int w = 1; w < 7; w++) begin
      checks++; if (w_data[w] !== 32'd0) begin errors++; $display("FAIL midrst_zero[%0d] got=%0d exp=0", w, w_data[w]); end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] sd [7];
    logic [2:0] si [7];
    s_ev = 5'b00100;
    repeat (255) tick();
    checks++; if (s_ovf[3] !== 1'b0) begin errors++; $display("FAIL sat_at_max_no_ovf got=%0b exp=0", s_ovf[3]); end
    repeat (45) tick();
    s_ev = 5'b00000;
    checks++; if (s_ovf !== 6'b001001) begin errors++; $display("FAIL sat_overflow got=%b exp=001001", s_ovf); end
    s_if.dump_v_i = 1'b1;
    tick();
    s_if.dump_v_i = 1'b0;
    checks++; if (s_ovf !== 6'b000000) begin errors++; $display("FAIL sat_ovf_cleared got=%b exp=000000", s_ovf); end
    for (int w = 0; w < 7; w++) begin
      @(negedge clk);
      sd[w] = s_if.data_v_o ? s_if.data_o : 8'hxx;
      si[w] = s_if.data_idx_o;
      tick();
    end
    checks++; if (sd[0] !== 8'h06) begin errors++; $display("FAIL sat_header got=%0h exp=06", sd[0]); end
    checks++; if (sd[1] !== 8'hFF) begin errors++; $display("FAIL sat_cycles got=%0h exp=ff", sd[1]); end
    checks++; if (sd[4] !== 8'hFF || si[4] !== 3'd4) begin errors++; $display("FAIL sat_ctr3 got=%0h idx=%0d exp=ff idx=4", sd[4], si[4]); end
    checks++; if (sd[2] !== 8'h00 || sd[3] !== 8'h00 || sd[5] !== 8'h00 || sd[6] !== 8'h00) begin errors++; $display("FAIL sat_others got=%0h,%0h,%0h,%0h exp 0", sd[2], sd[3], sd[5], sd[6]); end
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1; en = 1'b0; ev = '0;
    s_en = 1'b1; s_ev = '0;
    m_if.dump_v_i = 1'b0; m_if.data_ready_i = 1'b1;
    s_if.dump_v_i = 1'b0; s_if.data_ready_i = 1'b1;
    test_reset();
    test_basic();
    test_events();
    test_backpressure();
    test_enable();
    test_reset_mid_stream();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
